// File: rtl/p2s_spi_tx_pkg.sv
// Shared helpers for the parallel-to-serial SPI transmitter and its tick generator.
package p2s_spi_tx_pkg;

    // Width of a counter that must hold the values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/p2s_spi_tx_clk_en_gen.sv
// Reloadable clock-enable generator: one-cycle tick every DIV enabled cycles.
module clk_en_gen
    import p2s_spi_tx_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned   CW     = cnt_width(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("clk_en_gen: DIV must be >= 1");
    end

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && !i_clr && (r_cnt == '0);

    // Down-counter; clear preloads a full period, reaching zero reloads it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= RELOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/p2s_spi_tx.sv
// Parallel-to-serial SPI mode-0 transmitter with a one-word holding register.
module p2s_spi_tx
    import p2s_spi_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 2,
    parameter int LSB_FIRST = 0,
    parameter int CONT      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             sclk,
    output logic             d_out,
    output logic             cs_n,
    output logic             busy
);

    localparam int unsigned   BW       = cnt_width(WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("p2s_spi_tx: WIDTH must be in 2..32");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("p2s_spi_tx: CLK_DIV must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GUARD
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bitcnt;
    logic             r_sclk;
    logic             r_dout;
    logic             r_cs_n;

    logic             w_tick;
    logic             w_div_clr;
    logic             w_div_en;
    logic             w_load;
    logic             w_rise;
    logic             w_fall;
    logic             w_shift;
    logic             w_release;
    logic             w_hold_first;
    logic [WIDTH-1:0] w_shifted;
    logic             w_shift_first;

    assign w_hold_first  = (LSB_FIRST != 0) ? r_hold[0] : r_hold[WIDTH-1];
    assign w_shifted     = (LSB_FIRST != 0) ? (r_shreg >> 1) : (r_shreg << 1);
    assign w_shift_first = (LSB_FIRST != 0) ? w_shifted[0] : w_shifted[WIDTH-1];

    assign w_div_clr = (r_state == IDLE);
    assign w_div_en  = (r_state != IDLE);

    clk_en_gen #(
        .DIV (CLK_DIV)
    ) u_div (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (w_div_clr),
        .i_en    (w_div_en),
        .o_tick  (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and one-cycle datapath strobes.
    // GUARD expiry with a word already held starts the next frame directly,
    // so the cs_n high gap between frames is exactly CLK_DIV cycles.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_rise    = 1'b0;
        w_fall    = 1'b0;
        w_shift   = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load = 1'b1;
                    w_next = SETUP;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (!r_sclk) begin
                        w_rise = 1'b1;
                    end else begin
                        w_fall = 1'b1;
                        if (r_bitcnt != BIT_LAST) begin
                            w_shift = 1'b1;
                        end else if ((CONT != 0) && r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_next = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_release = 1'b1;
                    w_next    = GUARD;
                end
            end
            GUARD: begin
                if (w_tick) begin
                    if (r_hold_full) begin
                        w_load = 1'b1;
                        w_next = SETUP;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Holding register: accept when empty, release when copied into the shifter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (d_valid && !r_hold_full) begin
            r_hold      <= d_in;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Shift register and MOSI; data moves only on falling sclk or a (re)load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg <= '0;
            r_dout  <= 1'b0;
        end else if (w_load) begin
            r_shreg <= r_hold;
            r_dout  <= w_hold_first;
        end else if (w_shift) begin
            r_shreg <= w_shifted;
            r_dout  <= w_shift_first;
        end else if (w_release) begin
            r_dout  <= 1'b0;
        end
    end

    // Bit counter: number of rising sclk edges issued for the current word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt <= '0;
        end else if (w_load) begin
            r_bitcnt <= '0;
        end else if (w_rise) begin
            r_bitcnt <= r_bitcnt + 1'b1;
        end
    end

    // Serial clock, idle low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk <= 1'b0;
        end else if (w_rise) begin
            r_sclk <= 1'b1;
        end else if (w_fall) begin
            r_sclk <= 1'b0;
        end
    end

    // Frame select: low from frame start until HOLD expires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_n <= 1'b1;
        end else if (w_load) begin
            r_cs_n <= 1'b0;
        end else if (w_release) begin
            r_cs_n <= 1'b1;
        end
    end

    assign d_ready = !r_hold_full;
    assign sclk    = r_sclk;
    assign d_out   = r_dout;
    assign cs_n    = r_cs_n;
    assign busy    = !r_cs_n || r_hold_full;

endmodule

// File: tb/tb_p2s_spi_tx.sv
// Scoreboard bench: two transmitter configurations against a bit-sequence model.
module tb_p2s_spi_tx;

    localparam int AW = 8;
    localparam int AD = 2;
    localparam int BW = 16;
    localparam int BD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, rst_b;
    logic [AW-1:0] a_din;
    logic          a_valid, a_ready, a_sclk, a_dout, a_cs_n, a_busy;
    logic [BW-1:0] b_din;
    logic          b_valid, b_ready, b_sclk, b_dout, b_cs_n, b_busy;

    // A: 8-bit, MSB first, continuous frames.
    p2s_spi_tx #(.WIDTH(AW), .CLK_DIV(AD), .LSB_FIRST(0), .CONT(1)) u_a (
        .clk(clk), .reset_n(rst_a), .d_in(a_din), .d_valid(a_valid), .d_ready(a_ready),
        .sclk(a_sclk), .d_out(a_dout), .cs_n(a_cs_n), .busy(a_busy));

    // B: 16-bit, LSB first, one frame per word.
    p2s_spi_tx #(.WIDTH(BW), .CLK_DIV(BD), .LSB_FIRST(1), .CONT(0)) u_b (
        .clk(clk), .reset_n(rst_b), .d_in(b_din), .d_valid(b_valid), .d_ready(b_ready),
        .sclk(b_sclk), .d_out(b_dout), .cs_n(b_cs_n), .busy(b_busy));

    int checks = 0;
    int errors = 0;

    bit a_bits[$];
    bit b_bits[$];
    int a_frames[$];
    int b_frames[$];
    int b_gaps[$];

    int   a_len, a_edges, a_hi, b_len, b_edges, b_hi;
    logic a_psclk, a_pcs, b_psclk, b_pcs;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the serial bit sequence a word must produce on MOSI.
    task automatic expect_a(input logic [AW-1:0] w);
        for (int n = 0; n < AW; n++) a_bits.push_back(w[AW-1-n]);
    endtask

    task automatic expect_b(input logic [BW-1:0] w);
        for (int n = 0; n < BW; n++) b_bits.push_back(w[n]);
        b_frames.push_back(BW);
    endtask

    task automatic send_a(input logic [AW-1:0] w);
        int unsigned n = 0;
        @(negedge clk);
        a_din   = w;
        a_valid = 1'b1;
        while (!a_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("a_accept_timeout", int'(n < 2000), 1);
        if (n < 2000) expect_a(w);
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [BW-1:0] w);
        int unsigned n = 0;
        @(negedge clk);
        b_din   = w;
        b_valid = 1'b1;
        while (!b_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("b_accept_timeout", int'(n < 2000), 1);
        if (n < 2000) expect_b(w);
        @(posedge clk);
        #1 b_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int unsigned n = 0;
        while ((a_busy || a_bits.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("a_idle_timeout", int'(n < 5000), 1);
        repeat (2 * AD + 2) @(negedge clk);
    endtask

    task automatic wait_idle_b();
        int unsigned n = 0;
        while ((b_busy || b_bits.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("b_idle_timeout", int'(n < 5000), 1);
        repeat (2 * BD + 2) @(negedge clk);
    endtask

    // Monitor A: bits at rising sclk, frame length, MOSI quiet outside frames.
    always @(negedge clk) begin
        if (!rst_a) begin
            a_psclk = 1'b0; a_pcs = 1'b1; a_len = 0; a_edges = 0; a_hi = 1000;
        end else begin
            if (a_cs_n) chk("a_dout_idle", a_dout, 0);
            if (!a_cs_n) begin
                if (a_pcs) begin
                    chk("a_gap_min", int'(a_hi >= AD), 1);
                    a_len = 0; a_edges = 0;
                end
                a_len++;
            end else begin
                if (!a_pcs) begin
                    chk("a_frame_len", a_len, (2 * a_edges + 2) * AD);
                    chk("a_frame_words", a_edges % AW, 0);
                    if (a_frames.size() != 0) chk("a_frame_edges", a_edges, a_frames.pop_front());
                    a_hi = 0;
                end
                a_hi++;
            end
            if (a_sclk && !a_psclk) begin
                chk("a_sclk_in_frame", a_cs_n, 0);
                chk("a_bit_expected", int'(a_bits.size() > 0), 1);
                if (a_bits.size() > 0) chk("a_bit", a_dout, a_bits.pop_front());
                a_edges++;
            end
            a_psclk = a_sclk;
            a_pcs   = a_cs_n;
        end
    end

    // Monitor B: same checks plus exact inter-frame gaps where requested.
    always @(negedge clk) begin
        if (!rst_b) begin
            b_psclk = 1'b0; b_pcs = 1'b1; b_len = 0; b_edges = 0; b_hi = 1000;
        end else begin
            if (b_cs_n) chk("b_dout_idle", b_dout, 0);
            if (!b_cs_n) begin
                if (b_pcs) begin
                    chk("b_gap_min", int'(b_hi >= BD), 1);
                    if (b_gaps.size() != 0) chk("b_gap", b_hi, b_gaps.pop_front());
                    b_len = 0; b_edges = 0;
                end
                b_len++;
            end else begin
                if (!b_pcs) begin
                    chk("b_frame_len", b_len, (2 * b_edges + 2) * BD);
                    if (b_frames.size() != 0) chk("b_frame_edges", b_edges, b_frames.pop_front());
                    b_hi = 0;
                end
                b_hi++;
            end
            if (b_sclk && !b_psclk) begin
                chk("b_sclk_in_frame", b_cs_n, 0);
                chk("b_bit_expected", int'(b_bits.size() > 0), 1);
                if (b_bits.size() > 0) chk("b_bit", b_dout, b_bits.pop_front());
                b_edges++;
            end
            b_psclk = b_sclk;
            b_pcs   = b_cs_n;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int unsigned n;
        a_din = '0; a_valid = 1'b0; b_din = '0; b_valid = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("a_rst_cs_n", a_cs_n, 1);  chk("a_rst_sclk", a_sclk, 0);
        chk("a_rst_dout", a_dout, 0);  chk("a_rst_ready", a_ready, 1);
        chk("a_rst_busy", a_busy, 0);
        chk("b_rst_cs_n", b_cs_n, 1);  chk("b_rst_sclk", b_sclk, 0);
        chk("b_rst_ready", b_ready, 1);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (4) @(negedge clk);

        // Isolated 0xA5 frame with d_ready handshake timing.
        a_frames.push_back(AW);
        a_din   = 8'hA5;
        a_valid = 1'b1;
        chk("a5_ready_before", a_ready, 1);
        expect_a(8'hA5);
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        chk("a5_ready_low", a_ready, 0);
        chk("a5_busy", a_busy, 1);
        @(negedge clk);
        chk("a5_ready_back", a_ready, 1);
        chk("a5_cs_low", a_cs_n, 0);
        wait_idle_a();

        // Back-to-back pair in one frame; a third word while full is ignored.
        a_frames.push_back(2 * AW);
        send_a(8'h3C);
        send_a(8'hC3);
        @(negedge clk);
        a_din   = 8'hFF;
        a_valid = 1'b1;
        chk("a_full_ready", a_ready, 0);
        chk("a_full_busy", a_busy, 1);
        repeat (10) @(negedge clk);
        chk("a_full_ready_still", a_ready, 0);
        a_valid = 1'b0;
        wait_idle_a();

        // Random traffic on A: mixes merged and isolated frames.
        for (int i = 0; i < 30; i++) begin
            int unsigned gap;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            send_a(AW'($urandom));
        end
        wait_idle_a();

        // LSB-first single set bit.
        send_b(16'h0001);
        wait_idle_b();

        // Two words, separate frames with a CLK_DIV-cycle gap.
        send_b(16'h003C);
        send_b(16'h00C3);
        b_gaps.push_back(BD);
        wait_idle_b();

        // Random traffic on B.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            send_b(BW'($urandom));
        end
        wait_idle_b();

        // Reset after three rising edges of a frame.
        send_b(16'hA55A);
        n = 0;
        while ((b_cs_n || b_edges < 3) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("b_rst_reach3", b_edges, 3);
        @(posedge clk);
        #1 rst_b = 1'b0;
        b_bits.delete();
        b_frames.delete();
        b_gaps.delete();
        #1;
        chk("b_abort_cs_n", b_cs_n, 1);
        chk("b_abort_sclk", b_sclk, 0);
        chk("b_abort_dout", b_dout, 0);
        chk("b_abort_ready", b_ready, 1);
        chk("b_abort_busy", b_busy, 0);
        repeat (10) @(negedge clk);
        chk("b_abort_sclk_held", b_sclk, 0);
        rst_b = 1'b1;
        send_b(16'h8001);
        wait_idle_b();

        chk("a_bits_left", a_bits.size(), 0);
        chk("b_bits_left", b_bits.size(), 0);
        chk("a_frames_left", a_frames.size(), 0);
        chk("b_frames_left", b_frames.size(), 0);
        chk("b_gaps_left", b_gaps.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
